// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction-fetch stage.
// Optional perf counters in fetch_unit are enabled by defining FETCH_PERF_EN.
package fetch_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0;
    localparam logic [31:0] PC_INCR   = 32'd4;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        WAIT    = 2'd1,
        DISCARD = 2'd2
    } fetch_state_t;

    // Prefetch queue entry: PC+4 of the word and the word itself.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } qentry_t;

endpackage

// File: rtl/fetch_queue.sv
// Small prefetch FIFO of QDEPTH 64-bit entries; flush beats push.
module fetch_queue #(
    parameter  int QDEPTH = 2,
    localparam int CW     = $clog2(QDEPTH) + 1,
    localparam int AW     = (QDEPTH > 1) ? $clog2(QDEPTH) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [63:0]   din,
    input  logic          pop,
    input  logic          flush,
    output logic [CW-1:0] count,
    output logic [63:0]   head
);

    logic [63:0]   mem [QDEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;

    function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
        return (p == AW'(QDEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= inc(wr_ptr);
            if (pop)  rd_ptr <= inc(rd_ptr);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Storage carries no reset; count alone decides what is live.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= din;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, issues one-at-a-time IMem requests, drives IF/ID.
// Define FETCH_PERF_EN to add the BubbleCount / RedirectCount ports.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 2
) (
    input  logic        Clk,
    input  logic        Rst,
    output logic        IMemReq,
    output logic [31:0] IMemAddr,
    input  logic        IMemAck,
    input  logic [31:0] IMemData,
    input  logic        Stall,
    input  logic        PCSrc,
    input  logic [31:0] BranchPC,
    input  logic        Jump,
    input  logic [31:0] JumpPC,
    output logic [31:0] OutPC,
    output logic [31:0] Instr,
    output logic        IFIDValid
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] BubbleCount,
    output logic [31:0] RedirectCount
`endif
);

    localparam int            CW    = $clog2(QDEPTH) + 1;
    localparam logic [CW-1:0] QFULL = CW'(QDEPTH);
    localparam logic [CW-1:0] QLAST = CW'(QDEPTH - 1);

    fetch_state_t  state, state_d;
    logic [31:0]   fetch_pc, fetch_pc_d, addr_d, target;
    logic          req_d, push, pop, redirect, room;
    logic [CW-1:0] count;
    qentry_t       head, din;

    assign redirect = PCSrc | Jump;
    assign target   = PCSrc ? BranchPC : JumpPC;
    assign pop      = !redirect && !Stall && (count != '0);
    // Room for another word once this cycle's push (and any pop) land.
    assign room     = pop ? (count < QFULL) : (count < QLAST);
    assign din      = {fetch_pc + PC_INCR, IMemData};

    fetch_queue #(.QDEPTH(QDEPTH)) u_queue (
        .clk   (Clk),
        .rst   (Rst),
        .push  (push),
        .din   (din),
        .pop   (pop),
        .flush (redirect),
        .count (count),
        .head  (head)
    );

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state    <= RUN;
            fetch_pc <= RESET_PC;
            IMemReq  <= 1'b0;
            IMemAddr <= RESET_PC;
        end else begin
            state    <= state_d;
            fetch_pc <= fetch_pc_d;
            IMemReq  <= req_d;
            IMemAddr <= addr_d;
        end
    end

    always_comb begin
        state_d = state;
        unique case (state)
            RUN: begin
                if (!redirect && count < QFULL) state_d = WAIT;
            end
            WAIT: begin
                if (redirect)               state_d = IMemAck ? RUN : DISCARD;
                else if (IMemAck && !room)  state_d = RUN;
            end
            DISCARD: begin
                if (IMemAck) state_d = redirect ? RUN : WAIT;
            end
            default: state_d = RUN;
        endcase
    end

    // Request-side outputs: a held request keeps its address until acked.
    always_comb begin
        fetch_pc_d = fetch_pc;
        req_d      = IMemReq;
        addr_d     = IMemAddr;
        push       = 1'b0;
        unique case (state)
            RUN: begin
                if (redirect) begin
                    fetch_pc_d = target;
                    req_d      = 1'b0;
                end else if (count < QFULL) begin
                    req_d  = 1'b1;
                    addr_d = fetch_pc;
                end
            end
            WAIT: begin
                if (redirect) begin
                    fetch_pc_d = target;
                    req_d      = !IMemAck;
                end else if (IMemAck) begin
                    push       = 1'b1;
                    fetch_pc_d = fetch_pc + PC_INCR;
                    req_d      = room;
                    addr_d     = fetch_pc + PC_INCR;
                end
            end
            DISCARD: begin
                if (redirect) begin
                    fetch_pc_d = target;
                    if (IMemAck) req_d = 1'b0;
                end else if (IMemAck) begin
                    req_d  = 1'b1;
                    addr_d = fetch_pc;
                end
            end
            default: req_d = 1'b0;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            Instr     <= NOP_INSTR;
            OutPC     <= '0;
            IFIDValid <= 1'b0;
        end else if (redirect) begin
            Instr     <= NOP_INSTR;
            IFIDValid <= 1'b0;
        end else if (!Stall) begin
            if (pop) begin
                OutPC     <= head.pc;
                Instr     <= head.instr;
                IFIDValid <= 1'b1;
            end else begin
                Instr     <= NOP_INSTR;
                IFIDValid <= 1'b0;
            end
        end
    end

`ifdef FETCH_PERF_EN
    logic bubble;
    assign bubble = !redirect && !Stall && !pop;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            BubbleCount   <= '0;
            RedirectCount <= '0;
        end else begin
            if (bubble && BubbleCount != '1)     BubbleCount   <= BubbleCount + 32'd1;
            if (redirect && RedirectCount != '1) RedirectCount <= RedirectCount + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed and randomized checks of fetch_unit against a memory model and an IF/ID stream scoreboard.
module tb_fetch_unit;

    logic        Clk = 1'b0;
    logic        Rst = 1'b0;
    logic        IMemReq;
    logic [31:0] IMemAddr;
    logic        IMemAck = 1'b0;
    logic [31:0] IMemData = '0;
    logic        Stall = 1'b0, PCSrc = 1'b0, Jump = 1'b0;
    logic [31:0] BranchPC = '0, JumpPC = '0;
    logic [31:0] OutPC, Instr;
    logic        IFIDValid;
`ifdef FETCH_PERF_EN
    logic [31:0] BubbleCount, RedirectCount;
`endif

    fetch_unit #(.RESET_PC(32'h0), .QDEPTH(2)) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .IMemReq   (IMemReq),
        .IMemAddr  (IMemAddr),
        .IMemAck   (IMemAck),
        .IMemData  (IMemData),
        .Stall     (Stall),
        .PCSrc     (PCSrc),
        .BranchPC  (BranchPC),
        .Jump      (Jump),
        .JumpPC    (JumpPC),
        .OutPC     (OutPC),
        .Instr     (Instr),
        .IFIDValid (IFIDValid)
`ifdef FETCH_PERF_EN
        ,
        .BubbleCount   (BubbleCount),
        .RedirectCount (RedirectCount)
`endif
    );

    always #5 Clk = ~Clk;

    int          tests = 0;
    int          fails = 0;
    int          lat   = 0;
    int          wcnt  = 0;
    bit          busy  = 1'b0;
    logic [31:0] dmask = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_ifid(input string tag, input logic [31:0] i, input logic [31:0] p, input logic v);
        chk({tag, ".instr"}, Instr, i);
        chk({tag, ".outpc"}, OutPC, p);
        chk1({tag, ".valid"}, IFIDValid, v);
    endtask

    // Memory answers each new request after 'lat' idle cycles; data = addr ^ dmask.
    task automatic mem_model();
        if (IMemReq) begin
            if (!busy) begin
                busy = 1'b1;
                wcnt = lat;
            end
            if (wcnt == 0) begin
                IMemAck  = 1'b1;
                IMemData = IMemAddr ^ dmask;
                busy     = 1'b0;
            end else begin
                IMemAck = 1'b0;
                wcnt--;
            end
        end else begin
            IMemAck = 1'b0;
            busy    = 1'b0;
        end
    endtask

    task automatic cyc();
        @(posedge Clk);
        #1;
        mem_model();
    endtask

    task automatic do_reset();
        Rst = 1'b1; IMemAck = 1'b0; busy = 1'b0;
        Stall = 1'b0; PCSrc = 1'b0; Jump = 1'b0;
        @(posedge Clk);
        #1;
        Rst = 1'b0;
        mem_model();
    endtask

    function automatic logic [31:0] pick_target();
        logic [31:0] r;
        r = $urandom;
        if ($urandom_range(0, 3) == 0) r = 32'hFFFF_FFF8;
        return r & ~32'h3;
    endfunction

    logic [31:0] p_instr, p_outpc, p_addr, exp_pc, tgt;
    logic        p_valid, p_req, p_ack, st, rd;
    int          run, max_run;

    initial begin
        // reset state
        #2 Rst = 1'b1;
        #1;
        chk1("rst.req", IMemReq, 1'b0);
        chk("rst.addr", IMemAddr, 32'h0);
        chk_ifid("rst", 32'h0, 32'h0, 1'b0);
        @(posedge Clk); #1;
        Rst = 1'b0;
        mem_model();

        // zero-wait memory, data = addr
        cyc(); chk1("zw.req1", IMemReq, 1'b1); chk("zw.addr0", IMemAddr, 32'h0);
        cyc(); chk("zw.addr4", IMemAddr, 32'h4); chk1("zw.e2.valid", IFIDValid, 1'b0);
        cyc(); chk("zw.addr8", IMemAddr, 32'h8); chk_ifid("zw.e3", 32'h0, 32'h4, 1'b1);
        cyc(); chk("zw.addr12", IMemAddr, 32'hC); chk_ifid("zw.e4", 32'h4, 32'h8, 1'b1);

        // slow memory: request held, bubbles for missing words
        lat = 2; do_reset();
        cyc(); chk1("slow.e1.req", IMemReq, 1'b1); chk("slow.e1.addr", IMemAddr, 32'h0);
        cyc(); chk1("slow.e2.req", IMemReq, 1'b1); chk("slow.e2.addr", IMemAddr, 32'h0);
        chk1("slow.e2.valid", IFIDValid, 1'b0);
        cyc(); chk1("slow.e3.req", IMemReq, 1'b1); chk("slow.e3.addr", IMemAddr, 32'h0);
        cyc(); chk("slow.e4.addr", IMemAddr, 32'h4);
        cyc(); chk_ifid("slow.e5", 32'h0, 32'h4, 1'b1);
        cyc(); chk_ifid("slow.e6", 32'h0, 32'h4, 1'b0);
        cyc(); chk1("slow.e7.valid", IFIDValid, 1'b0); chk("slow.e7.addr", IMemAddr, 32'h8);
        cyc(); chk_ifid("slow.e8", 32'h4, 32'h8, 1'b1);

        // stall with a filling queue
        lat = 0; do_reset();
        cyc(); cyc(); cyc(); chk_ifid("stall.e3", 32'h0, 32'h4, 1'b1);
        Stall = 1'b1;
        cyc(); chk1("stall.e4.req", IMemReq, 1'b0); chk_ifid("stall.e4", 32'h0, 32'h4, 1'b1);
        cyc(); chk1("stall.e5.req", IMemReq, 1'b0); chk_ifid("stall.e5", 32'h0, 32'h4, 1'b1);
        Stall = 1'b0;
        cyc(); chk_ifid("stall.e6", 32'h4, 32'h8, 1'b1); chk1("stall.e6.req", IMemReq, 1'b0);
        cyc(); chk_ifid("stall.e7", 32'h8, 32'hC, 1'b1);
        chk1("stall.e7.req", IMemReq, 1'b1); chk("stall.e7.addr", IMemAddr, 32'hC);
        cyc(); chk1("stall.e8.valid", IFIDValid, 1'b0);
        cyc(); chk_ifid("stall.e9", 32'hC, 32'h10, 1'b1);

        // branch while waiting at 0x10: old request completes and is dropped
        lat = 0; do_reset();
        repeat (4) cyc();
        lat = 2;
        cyc(); chk("br.e5.addr", IMemAddr, 32'h10); chk_ifid("br.e5", 32'h8, 32'hC, 1'b1);
        PCSrc = 1'b1; BranchPC = 32'h100;
        cyc(); PCSrc = 1'b0;
        chk1("br.e6.req", IMemReq, 1'b1); chk("br.e6.addr", IMemAddr, 32'h10);
        chk_ifid("br.e6", 32'h0, 32'hC, 1'b0);
        cyc(); chk1("br.e7.req", IMemReq, 1'b1); chk("br.e7.addr", IMemAddr, 32'h10);
        chk1("br.e7.valid", IFIDValid, 1'b0);
        cyc(); chk1("br.e8.req", IMemReq, 1'b1); chk("br.e8.addr", IMemAddr, 32'h100);
        chk1("br.e8.valid", IFIDValid, 1'b0);
        for (int k = 0; k < 3; k++) begin
            cyc(); chk1("br.wait.valid", IFIDValid, 1'b0);
        end
        cyc(); chk_ifid("br.e12", 32'h100, 32'h104, 1'b1);

        // branch + jump + stall + ack all in one cycle
        lat = 0; do_reset();
        cyc(); cyc(); cyc(); chk_ifid("both.e3", 32'h0, 32'h4, 1'b1);
        PCSrc = 1'b1; BranchPC = 32'h40; Jump = 1'b1; JumpPC = 32'h80; Stall = 1'b1;
        cyc(); PCSrc = 1'b0; Jump = 1'b0; Stall = 1'b0;
        chk1("both.e4.req", IMemReq, 1'b0); chk_ifid("both.e4", 32'h0, 32'h4, 1'b0);
        cyc(); chk1("both.e5.req", IMemReq, 1'b1); chk("both.e5.addr", IMemAddr, 32'h40);
        cyc(); chk1("both.e6.valid", IFIDValid, 1'b0);
        cyc(); chk_ifid("both.e7", 32'h40, 32'h44, 1'b1);

        // asynchronous reset mid-request, then a stale ack
        lat = 0; do_reset();
        cyc(); cyc(); cyc(); chk_ifid("arst.e3", 32'h0, 32'h4, 1'b1);
        IMemAck = 1'b0; busy = 1'b0;
        #3 Rst = 1'b1;
        #1;
        chk1("arst.req", IMemReq, 1'b0); chk("arst.addr", IMemAddr, 32'h0);
        chk_ifid("arst", 32'h0, 32'h0, 1'b0);
        @(posedge Clk); #1;
        Rst = 1'b0; IMemAck = 1'b1; IMemData = 32'hDEAD_BEEF;
        cyc(); chk1("arst.s1.req", IMemReq, 1'b1); chk("arst.s1.addr", IMemAddr, 32'h0);
        chk1("arst.s1.valid", IFIDValid, 1'b0);
        cyc(); chk_ifid("arst.s2", 32'h0, 32'h0, 1'b0);
        cyc(); chk_ifid("arst.s3", 32'h0, 32'h4, 1'b1);

        // randomized: IF/ID must present consecutive words from the last redirect target
        dmask = $urandom;
        lat = 0; do_reset();
        exp_pc = 32'h0; run = 0; max_run = 0; tgt = '0;
        for (int n = 0; n < 800; n++) begin
            lat = $urandom_range(0, 3);
            p_instr = Instr; p_outpc = OutPC; p_valid = IFIDValid;
            p_req = IMemReq; p_addr = IMemAddr; p_ack = IMemAck;
            st = ($urandom_range(0, 3) == 0);
            rd = ($urandom_range(0, 15) == 0);
            Stall = st; PCSrc = 1'b0; Jump = 1'b0;
            if (rd) begin
                BranchPC = pick_target();
                JumpPC   = pick_target();
                case ($urandom_range(0, 2))
                    0:       PCSrc = 1'b1;
                    1:       Jump  = 1'b1;
                    default: begin PCSrc = 1'b1; Jump = 1'b1; end
                endcase
                tgt = PCSrc ? BranchPC : JumpPC;
            end
            cyc();
            if (p_req && !p_ack) begin
                chk1("rnd.hold.req", IMemReq, 1'b1);
                chk("rnd.hold.addr", IMemAddr, p_addr);
            end
            if (rd) begin
                chk1("rnd.redir.valid", IFIDValid, 1'b0);
                chk("rnd.redir.instr", Instr, 32'h0);
                exp_pc = tgt;
                run = 0;
            end else if (st) begin
                chk_ifid("rnd.stall", p_instr, p_outpc, p_valid);
            end else if (IFIDValid) begin
                chk("rnd.instr", Instr, exp_pc ^ dmask);
                chk("rnd.outpc", OutPC, exp_pc + 32'd4);
                exp_pc = exp_pc + 32'd4;
                run = 0;
            end else begin
                chk("rnd.bubble.instr", Instr, 32'h0);
                chk("rnd.bubble.outpc", OutPC, p_outpc);
                run++;
                if (run > max_run) max_run = run;
            end
        end
        Stall = 1'b0; PCSrc = 1'b0; Jump = 1'b0;
        chk1("rnd.max_bubble_run_ok", (max_run <= 20), 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage of the 5-stage pipelined CPU, directly upstream of decode.
- Owns the PC and issues one-at-a-time requests to instruction memory.
- Buffers returned words in a small prefetch queue and drives the IF/ID pipeline register (OutPC, Instr) consumed by decode.
- Accepts stall from hazard logic and redirects (PCSrc/BranchPC, Jump/JumpPC) from later stages.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address after reset.
- QDEPTH, 2, prefetch queue entries (power of 2, >= 1).

Ports:
- Clk  input  1  clock, rising edge
- Rst  input  1  asynchronous, active-high reset
- IMemReq  output  1  request valid; held until IMemAck
- IMemAddr  output  32  word-aligned fetch address; stable while IMemReq high
- IMemAck  input  1  response valid this cycle; may coincide with the IMemReq rise
- IMemData  input  32  instruction word, valid with IMemAck
- Stall  input  1  hold IF/ID register (load-use hazard)
- PCSrc  input  1  taken branch
- BranchPC  input  32  branch target
- Jump  input  1  jump
- JumpPC  input  32  jump target
- OutPC  output  32  PC+4 of instruction in IF/ID
- Instr  output  32  instruction in IF/ID (NOP = 32'h0 on bubble)
- IFIDValid  output  1  IF/ID holds a real instruction

Behaviour:
- Reset (async): FetchPC=RESET_PC, state RUN, queue empty, IMemReq=0, IMemAddr=RESET_PC, Instr=0, OutPC=0, IFIDValid=0.
- Issue rule: in RUN, assert IMemReq (registered) when queue count + outstanding < QDEPTH.
- FSM states:
  - RUN: no request outstanding. When the issue rule holds → WAIT, with IMemReq=1 and IMemAddr=FetchPC.
  - WAIT: request outstanding. On IMemAck: enqueue {FetchPC+4, IMemData} and set FetchPC+=4. If space remains after the enqueue, keep IMemReq=1 with the new address and stay in WAIT; otherwise drop IMemReq and go → RUN.
  - DISCARD: request outstanding but redirected. IMemReq stays high at the old address until IMemAck, which is dropped. Then issue at the redirect target → WAIT.
- Throughput: with a zero-wait memory (ack every cycle), one instruction per cycle.
- Latency: ack edge → queue; next edge → IF/ID. There is no bypass. Minimum 2 edges from ack to IF/ID.
- IF/ID update at each edge, in priority order:
  1. Redirect: flush to NOP, IFIDValid=0. This overrides Stall.
  2. Stall: hold all three outputs.
  3. Queue non-empty: pop head into OutPC/Instr, IFIDValid=1.
  4. Otherwise: bubble (Instr=0, OutPC held, IFIDValid=0).
- Redirect (PCSrc|Jump):
  - Target: PCSrc takes priority over Jump (BranchPC wins).
  - Queue is flushed and FetchPC := target.
  - If WAIT without ack this cycle → DISCARD.
  - If ack arrives in the same cycle as the redirect, the data is dropped and the next state is RUN.
  - Redirect in RUN → RUN; the target is issued next cycle.
- Queue boundaries:
  - Enqueue and pop in the same cycle are allowed, so the count is unchanged.
  - The issue rule guarantees no overflow; a pop on empty never occurs.
- FetchPC wraps modulo 2^32.
- A mid-operation Rst abandons any outstanding request. A late IMemAck after reset is ignored (state RUN).

Optional Feature:
- Macro FETCH_PERF_EN.
- When defined, add output ports BubbleCount[31:0] and RedirectCount[31:0]. Both reset to 0 and saturate at all-ones.
  - BubbleCount increments on each edge where IF/ID loads a bubble (case 4, not redirect or stall).
  - RedirectCount increments on each redirect edge.
- When undefined, the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package fetch_pkg:
  - NOP_INSTR = 32'h0
  - PC_INCR = 4
  - state encoding RUN=2'd0, WAIT=2'd1, DISCARD=2'd2
- Sub-module fetch_queue:
  - Parameterised QDEPTH × 64-bit FIFO (push, pop, flush, count, head).
  - Flush has priority over push.

Test Plan:
- Reset, zero-wait memory returns addr as data:
  - IMemAddr sequence 0, 4, 8 on consecutive cycles.
  - IF/ID shows Instr=0 then 4 with OutPC=4 then 8; IFIDValid high from the 3rd edge.
- Memory acks 3 cycles after req: IMemReq/IMemAddr stable for 3 cycles, one bubble per missing word, no duplicate addresses.
- Stall high for 2 cycles with a full queue: Instr/OutPC frozen; IMemReq drops once count=QDEPTH; order preserved after release.
- PCSrc=1, BranchPC=32'h100 while WAIT at 32'h10, ack 2 cycles later: IMemReq held at 32'h10, its data never appears, next IMemAddr=32'h100, IF/ID NOP for the interim.
- PCSrc=1 (BranchPC=32'h40) and Jump=1 (JumpPC=32'h80) together with Stall=1 and IMemAck=1: IF/ID flushed, IFIDValid=0, next fetch 32'h40, acked word dropped.
- Rst asserted asynchronously mid-WAIT: outputs immediately at reset values; a stale ack the next cycle is ignored; the fetch restarts at RESET_PC.
